xorshift_plus_checker: RTL and testbench

Receive-side stream checker for the xorshift+ random generator. It is seeded with the same seed pair as the upstream generator and consumes the generator's output stream through a valid/ready handshake. For every accepted word it computes the expected value and compares it with the received one. It keeps match and error statistics, and declares loss of sync after a run of consecutive mismatches. It sits at the sink end of generator links: loopback tests, BIST, and link integrity checks.

---
 rtl/xorshift_plus_checker.sv | 162 ++++++++++++++++
 tb/tb_xorshift_plus_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/xorshift_plus_checker.sv
// xorshift_plus_checker: sink-side checker for an xorshift+ generator stream.
// A local copy of the generator state predicts each word. Accepted words are
// compared against the prediction, match/error statistics are kept, and the
// checker declares loss of sync after ERR_LIMIT consecutive mismatches.
module xorshift_plus_checker #(
    parameter int BITSIZE   = 64,
    parameter int SHIFT0    = 23,
    parameter int SHIFT1    = 18,
    parameter int SHIFT2    = 5,
    parameter int CNTW      = 32,
    parameter int ERR_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BITSIZE-1:0] seed0,
    input  logic [BITSIZE-1:0] seed1,
    input  logic               load,
    input  logic               dinValid,
    input  logic [BITSIZE-1:0] din,
    output logic               dinReady,
    output logic [CNTW-1:0]    matchCnt,
    output logic [CNTW-1:0]    errCnt,
    output logic               errFlag,
    output logic               locked,
    output logic               lost,
    output logic [BITSIZE-1:0] lastExp,
    output logic [BITSIZE-1:0] lastGot
);

    // Wide enough to hold the value ERR_LIMIT itself.
    localparam int CW = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOST  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BITSIZE-1:0] s0_q, s0_d, s1_q, s1_d;
    logic [CNTW-1:0]    match_q, match_d, err_q, err_d;
    logic [BITSIZE-1:0] last_exp_q, last_exp_d, last_got_q, last_got_d;
    logic [CW-1:0]      cons_q, cons_d;
    logic               ready_q, ready_d;
    logic               err_flag_q, err_flag_d;
    logic               locked_q, locked_d;
    logic               lost_q, lost_d;

    logic [BITSIZE-1:0] t_a, t_b, n0, exp_w;
    logic               accept;

    // Generator model: next state0 and the word the generator emits now.
    always_comb begin
        t_a   = s1_q ^ (s1_q << SHIFT0);
        t_b   = t_a ^ (t_a >> SHIFT1);
        n0    = t_b ^ s0_q ^ (s0_q >> SHIFT2);
        exp_w = s0_q + n0;
    end

    // load wins over a same-cycle handshake; that word is dropped.
    assign accept = dinValid && ready_q && !load;

    // Next-state logic: state machine, model advance and statistics.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        match_d    = match_q;
        err_d      = err_q;
        last_exp_d = last_exp_q;
        last_got_d = last_got_q;
        cons_d     = cons_q;
        locked_d   = locked_q;
        err_flag_d = 1'b0;

        if (load) begin
            state_d    = ST_CHECK;
            s0_d       = seed0;
            s1_d       = seed1;
            match_d    = '0;
            err_d      = '0;
            last_exp_d = '0;
            last_got_d = '0;
            cons_d     = '0;
            locked_d   = 1'b0;
        end else begin
            case (state_q)
                ST_CHECK: begin
                    if (accept) begin
                        // The generator advanced regardless of what we received.
                        s0_d = n0;
                        s1_d = s0_q;
                        if (din == exp_w) begin
                            if (match_q != '1) match_d = match_q + CNTW'(1);
                            cons_d   = '0;
                            locked_d = 1'b1;
                        end else begin
                            if (err_q != '1) err_d = err_q + CNTW'(1);
                            last_exp_d = exp_w;
                            last_got_d = din;
                            err_flag_d = 1'b1;
                            locked_d   = 1'b0;
                            // cons_q < LIMIT while in CHECK, so this cannot overflow.
                            cons_d     = cons_q + CW'(1);
                            if (cons_d >= LIMIT) state_d = ST_LOST;
                        end
                    end
                end
                // LOST swallows words without touching model or counters.
                ST_LOST:  ;
                default:  ;
            endcase
        end

        ready_d = (state_d != ST_IDLE);
        lost_d  = (state_d == ST_LOST);
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s0_q       <= '0;
            s1_q       <= '0;
            match_q    <= '0;
            err_q      <= '0;
            last_exp_q <= '0;
            last_got_q <= '0;
            cons_q     <= '0;
            ready_q    <= 1'b0;
            err_flag_q <= 1'b0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together at the edge.
            state_q    <= state_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            match_q    <= match_d;
            err_q      <= err_d;
            last_exp_q <= last_exp_d;
            last_got_q <= last_got_d;
            cons_q     <= cons_d;
            ready_q    <= ready_d;
            err_flag_q <= err_flag_d;
            locked_q   <= locked_d;
            lost_q     <= lost_d;
        end
    end

    assign dinReady = ready_q;
    assign matchCnt = match_q;
    assign errCnt   = err_q;
    assign errFlag  = err_flag_q;
    assign locked   = locked_q;
    assign lost     = lost_q;
    assign lastExp  = last_exp_q;
    assign lastGot  = last_got_q;

endmodule

// File: tb/tb_xorshift_plus_checker.sv
// Testbench for xorshift_plus_checker. Stimulus pushes the expected register
// snapshot for every word it expects to be accepted; a monitor detects each
// handshake and compares the outputs of the following cycle.
module tb_xorshift_plus_checker;

    typedef struct packed {
        logic [31:0] m;
        logic [31:0] e;
        logic        ef;
        logic        lk;
        logic        ls;
        logic [63:0] le;
        logic [63:0] lg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] seed0 = '0, seed1 = '0;
    logic        load = 1'b0;
    logic        dinValid = 1'b0;
    logic [63:0] din = '0;
    logic        dinReady;
    logic [31:0] matchCnt, errCnt;
    logic        errFlag, locked, lost;
    logic [63:0] lastExp, lastGot;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    // Reference generator used only where hand values are impractical.
    logic [63:0] m_s0, m_s1;

    xorshift_plus_checker dut (
        .clk(clk), .rst_n(rst_n), .seed0(seed0), .seed1(seed1), .load(load),
        .dinValid(dinValid), .din(din), .dinReady(dinReady),
        .matchCnt(matchCnt), .errCnt(errCnt), .errFlag(errFlag),
        .locked(locked), .lost(lost), .lastExp(lastExp), .lastGot(lastGot)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_next(output logic [63:0] e);
        logic [63:0] t, n;
        t = m_s1 ^ (m_s1 << 23);
        t = t ^ (t >> 18);
        n = t ^ m_s0 ^ (m_s0 >> 5);
        e = m_s0 + n;
        m_s1 = m_s0;
        m_s0 = n;
    endtask

    function automatic exp_t mk(input int m, input int e, input logic ef, input logic lk,
                                input logic ls, input logic [63:0] le, input logic [63:0] lg);
        exp_t x;
        x.m = 32'(m); x.e = 32'(e); x.ef = ef; x.lk = lk; x.ls = ls; x.le = le; x.lg = lg;
        return x;
    endfunction

    task automatic send(input logic [63:0] d, input exp_t e);
        @(posedge clk); #1;
        load = 1'b0; dinValid = 1'b1; din = d;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        load = 1'b0; dinValid = 1'b0;
    endtask

    task automatic do_load(input logic [63:0] a, input logic [63:0] b);
        @(posedge clk); #1;
        load = 1'b1; seed0 = a; seed1 = b; dinValid = 1'b0;
        @(posedge clk); #1;
        load = 1'b0;
        m_s0 = a; m_s1 = b;
    endtask

    // Monitor: an accepted handshake seen this cycle is checked one cycle later.
    initial begin
        logic pending;
        exp_t x;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
                sb_q.delete();
            end else begin
                if (pending) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_unexpected_accept at %0t", $time);
                    end else begin
                        x = sb_q.pop_front();
                        check("matchCnt", 64'(matchCnt), 64'(x.m));
                        check("errCnt",   64'(errCnt),   64'(x.e));
                        check("errFlag",  64'(errFlag),  64'(x.ef));
                        check("locked",   64'(locked),   64'(x.lk));
                        check("lost",     64'(lost),     64'(x.ls));
                        check("lastExp",  lastExp,       x.le);
                        check("lastGot",  lastGot,       x.lg);
                    end
                end
                pending = dinValid && dinReady && !load;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] e [4];
        // Reset state and IDLE behaviour.
        #12;
        check("rst_dinReady", 64'(dinReady), 64'(0));
        check("rst_matchCnt", 64'(matchCnt), 64'(0));
        check("rst_lost",     64'(lost),     64'(0));
        @(negedge clk); rst_n = 1'b1;
        idle();
        @(posedge clk); #1; dinValid = 1'b1; din = 64'h1000044;
        repeat (3) @(posedge clk);
        #1; dinValid = 1'b0;
        @(negedge clk);
        check("idle_dinReady", 64'(dinReady), 64'(0));
        check("idle_matchCnt", 64'(matchCnt), 64'(0));
        check("idle_errCnt",   64'(errCnt),   64'(0));

        // Basic check with seeds 1/2.
        do_load(64'd1, 64'd2);
        @(negedge clk);
        check("load_dinReady", 64'(dinReady), 64'(1));
        check("load_locked",   64'(locked),   64'(0));
        send(64'h1000044, mk(1, 0, 0, 1, 0, 0, 0));
        send(64'h28800A3, mk(2, 0, 0, 1, 0, 0, 0));
        idle();

        // Single error followed by recovery.
        do_load(64'd1, 64'd2);
        send(64'h1000045, mk(0, 1, 1, 0, 0, 64'h1000044, 64'h1000045));
        send(64'h28800A3, mk(1, 1, 0, 1, 0, 64'h1000044, 64'h1000045));
        idle();

        // Loss of sync after four consecutive mismatches.
        do_load(64'd1, 64'd2);
        for (int i = 0; i < 4; i++) model_next(e[i]);
        for (int i = 0; i < 4; i++)
            send(e[i] ^ 64'h100, mk(0, i + 1, 1, 0, (i == 3), e[i], e[i] ^ 64'h100));
        send(64'h0,       mk(0, 4, 0, 0, 1, e[3], e[3] ^ 64'h100));
        send(64'h1000044, mk(0, 4, 0, 0, 1, e[3], e[3] ^ 64'h100));
        idle();
        @(negedge clk);
        check("lost_dinReady", 64'(dinReady), 64'(1));
        check("lost_hold",     64'(lost),     64'(1));
        do_load(64'd1, 64'd2);
        @(negedge clk);
        check("reload_lost",    64'(lost),    64'(0));
        check("reload_errCnt",  64'(errCnt),  64'(0));
        check("reload_lastExp", lastExp,      64'(0));

        // load colliding with a wrong word: the word is ignored.
        @(posedge clk); #1;
        load = 1'b1; seed0 = 64'd1; seed1 = 64'd2; dinValid = 1'b1; din = 64'hDEAD;
        @(posedge clk); #1;
        load = 1'b0; dinValid = 1'b0;
        @(negedge clk);
        check("coll_errCnt",   64'(errCnt),   64'(0));
        check("coll_matchCnt", 64'(matchCnt), 64'(0));
        check("coll_errFlag",  64'(errFlag),  64'(0));
        check("coll_dinReady", 64'(dinReady), 64'(1));
        send(64'h1000044, mk(1, 0, 0, 1, 0, 0, 0));
        idle();

        // Handshake gap: no model state is skipped.
        do_load(64'd1, 64'd2);
        send(64'h1000044, mk(1, 0, 0, 1, 0, 0, 0));
        idle();
        send(64'h28800A3, mk(2, 0, 0, 1, 0, 0, 0));
        idle();

        // Asynchronous reset mid-stream.
        do_load(64'd1, 64'd2);
        send(64'h1000045, mk(0, 1, 1, 0, 0, 64'h1000044, 64'h1000045));
        send(64'h28800A3, mk(1, 1, 0, 1, 0, 64'h1000044, 64'h1000045));
        @(posedge clk); #1;
        dinValid = 1'b1; din = 64'h0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_matchCnt", 64'(matchCnt), 64'(0));
        check("arst_errCnt",   64'(errCnt),   64'(0));
        check("arst_lastExp",  lastExp,       64'(0));
        check("arst_lastGot",  lastGot,       64'(0));
        check("arst_locked",   64'(locked),   64'(0));
        check("arst_dinReady", 64'(dinReady), 64'(0));
        check("arst_errFlag",  64'(errFlag),  64'(0));
        dinValid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1; dinValid = 1'b1; din = 64'h1000044;
        @(posedge clk); #1; dinValid = 1'b0;
        @(negedge clk);
        check("post_rst_idle_ready", 64'(dinReady), 64'(0));
        check("post_rst_matchCnt",   64'(matchCnt), 64'(0));

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_drain: %0d expected words never accepted", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
